syzygy_adc_frame_align: RTL
===========================

Name: syzygy_adc_frame_align

Overview:
Parametrised successor to the single-lane frame bitslip logic. Takes the deserialised frame word plus NUM_LANES deserialised ADC data words, all in the divided-clock domain, and searches for the bit offset that makes the frame word equal FRAME_PATTERN. It applies that offset to every lane with an in-fabric barrel shifter, since ISERDESE3 has no native bitslip. It also tracks lock and loss of lock and re-aligns automatically. It sits between the per-lane IDELAYE3/ISERDESE3 pairs and the sample capture logic.

Parameters:
DATA_WIDTH, 8, deserialisation ratio; legal values 4 or 8.
NUM_LANES, 2, number of ADC data lanes aligned alongside the frame lane.
FRAME_PATTERN, 8'hF0, expected aligned frame word; only bits [DATA_WIDTH-1:0] are used.
SLIP_WAIT, 4, settle cycles after each offset change; minimum 4, checked by elaboration assertion.
LOCK_COUNT, 8, consecutive matches needed to declare lock; range 1..255.
UNLOCK_COUNT, 4, consecutive mismatches in LOCKED that drop lock; range 1..255.

Ports:
slow_clk  in  1  divided decode clock; all logic is in this domain
reset_n  in  1  asynchronous, active-low reset
ena  in  1  alignment enable (level)
frame_word  in  DATA_WIDTH  raw frame ISERDES Q
lane_data_in  in  NUM_LANES*DATA_WIDTH  raw data ISERDES Q; lane k at [k*DATA_WIDTH +: DATA_WIDTH]
lane_data_out  out  NUM_LANES*DATA_WIDTH  aligned lane words, registered
data_valid  out  1  high when lane_data_out is aligned (state LOCKED)
locked  out  1  same timing as data_valid; kept separate for status
align_fail  out  1  sticky; full offset sweep exhausted without lock
bitslip_count  out  $clog2(DATA_WIDTH)  current offset
relock_count  out  8  saturating count of lock losses

Behaviour:
- Reset (reset_n=0, async): state=IDLE; all outputs 0; prev-word registers 0.
- Shifter, per lane and for the frame lane: window = {prev_word, cur_word}, with prev in the MSBs. aligned = window[offset+DATA_WIDTH-1 : offset]. Output is registered, so latency is 1 slow_clk from input to lane_data_out. prev_word updates every cycle whatever the state.
- State IDLE: outputs data_valid, locked and the internal match/mismatch counters are 0. ena=1 moves to SETTLE with wait counter 0.
- State SETTLE: count SLIP_WAIT cycles, then go to CHECK.
- State CHECK: compare the registered aligned frame word with FRAME_PATTERN once per cycle.
  - Match: match_cnt++. At match_cnt==LOCK_COUNT go to LOCKED.
  - Mismatch: go to SLIP and clear match_cnt.
- State SLIP (1 cycle): offset <= (offset+1) mod DATA_WIDTH, wrapping DATA_WIDTH-1 -> 0; slip_attempts++.
  - If slip_attempts reaches 2*DATA_WIDTH, go to FAIL.
  - Otherwise go to SETTLE.
- State LOCKED: data_valid=locked=1, registered, asserted in the cycle after entry. Any single match clears mismatch_cnt. UNLOCK_COUNT consecutive mismatches:
  - deassert data_valid and locked next cycle;
  - relock_count++, saturating at 255;
  - clear slip_attempts;
  - go to SETTLE. The offset is retained, so re-search starts from the current offset.
- State FAIL: align_fail=1, data_valid=0. Stays until ena=0.
- ena=0 in any state: go to IDLE next cycle; data_valid, locked and align_fail clear; slip_attempts clears.
  - bitslip_count and relock_count are retained, so lanes stay at the last offset. Only reset_n clears them.
- ena re-asserted from IDLE restarts the search from the retained offset.
- lane_data_out is updated every cycle even when data_valid=0. Consumers qualify it with data_valid.
- Reset mid-search: asynchronous return to the reset values above. No partial pulse or glitch on data_valid.

Decomposition:
- Package adc_align_pkg holds:
  - the state enum (IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL);
  - the function computing the offset width;
  - the legal DATA_WIDTH constants.
- Sub-module adc_word_shifter (parameter DATA_WIDTH): prev register plus registered window select. It is instantiated NUM_LANES+1 times, once per data lane and once for the frame lane, and shares the offset.

Test Plan:
- Already-aligned stream (W=8, FRAME_PATTERN F0, frame input F0 repeating): lock with bitslip_count=0 and no SLIP. data_valid rises 1+SLIP_WAIT+LOCK_COUNT+1 cycles after ena, i.e. 14 cycles with defaults.
- Frame bits rotated, with lane k carrying the same rotation of byte 8'hA5+k: lock at bitslip_count=3 after 3 slips. lane_data_out matches A5/A6 exactly while data_valid=1.
- Constant frame input 8'h00: 16 slips, then align_fail=1 and data_valid=0. bitslip_count wraps 7->0 and ends at 0. ena=0 clears align_fail.
- Locked with defaults, inject 3 corrupt frame words then good ones: lock is held. Inject 4 consecutive corrupt words: locked falls, relock_count=1, then relock at the same offset.
- ena=0 while LOCKED at offset 5: data_valid=0 the next cycle and bitslip_count stays 5. Re-enable: lock with no slips.
- W=4, NUM_LANES=4, FRAME_PATTERN 4'hC: the offset search covers 0..3 and wraps 3->0. Assert reset_n low mid-SETTLE: all outputs are 0 immediately, asynchronously.

Source files
------------

// File: rtl/adc_align_pkg.sv
// Shared types and helpers for the SYZYGY ADC frame aligner.
package adc_align_pkg;

  localparam int unsigned DataWidthNarrow = 4;
  localparam int unsigned DataWidthWide   = 8;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StCheck,
    StSlip,
    StLocked,
    StFail
  } align_state_e;

  function automatic int unsigned offset_width(input int unsigned data_width);
    return (data_width > 1) ? $clog2(data_width) : 1;
  endfunction

endpackage

// File: rtl/adc_word_shifter.sv
// Barrel shifter for one deserialised lane: picks DATA_WIDTH bits out of {prev, cur}.
module adc_word_shifter
  import adc_align_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                                  slow_clk,
  input  logic                                  reset_n,
  input  logic [offset_width(DATA_WIDTH)-1:0]   offset,
  input  logic [DATA_WIDTH-1:0]                 cur_word,
  output logic [DATA_WIDTH-1:0]                 aligned
);

  logic [DATA_WIDTH-1:0]   prev_q;
  logic [DATA_WIDTH-1:0]   aligned_q;
  logic [DATA_WIDTH-1:0]   aligned_d;
  logic [2*DATA_WIDTH-1:0] window;

  assign window    = {prev_q, cur_word};
  assign aligned_d = window[offset +: DATA_WIDTH];
  assign aligned   = aligned_q;

  always_ff @(posedge slow_clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q    <= '0;
      aligned_q <= '0;
    end else begin
      prev_q    <= cur_word;
      aligned_q <= aligned_d;
    end
  end

endmodule

// File: rtl/syzygy_adc_frame_align.sv
// Frame-word bitslip search with lock tracking; applies the found offset to all data lanes.
module syzygy_adc_frame_align
  import adc_align_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned NUM_LANES     = 2,
  parameter logic [7:0]  FRAME_PATTERN = 8'hF0,
  parameter int unsigned SLIP_WAIT     = 4,
  parameter int unsigned LOCK_COUNT    = 8,
  parameter int unsigned UNLOCK_COUNT  = 4
) (
  input  logic                                slow_clk,
  input  logic                                reset_n,
  input  logic                                ena,
  input  logic [DATA_WIDTH-1:0]               frame_word,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]     lane_data_in,
  output logic [NUM_LANES*DATA_WIDTH-1:0]     lane_data_out,
  output logic                                data_valid,
  output logic                                locked,
  output logic                                align_fail,
  output logic [offset_width(DATA_WIDTH)-1:0] bitslip_count,
  output logic [7:0]                          relock_count
);

  localparam int unsigned OffW       = offset_width(DATA_WIDTH);
  localparam int unsigned WaitW      = $clog2(SLIP_WAIT);
  localparam int unsigned AttW       = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [WaitW-1:0] WaitLast   = WaitW'(SLIP_WAIT - 1);
  localparam logic [AttW-1:0]  AttLast    = AttW'(2 * DATA_WIDTH - 1);
  localparam logic [7:0]       LockLast   = 8'(LOCK_COUNT - 1);
  localparam logic [7:0]       UnlockLast = 8'(UNLOCK_COUNT - 1);

  if (DATA_WIDTH != DataWidthNarrow && DATA_WIDTH != DataWidthWide) begin : gen_bad_width
    $fatal(1, "DATA_WIDTH must be 4 or 8");
  end
  if (SLIP_WAIT < 4) begin : gen_bad_slip_wait
    $fatal(1, "SLIP_WAIT must be at least 4");
  end
  if (LOCK_COUNT < 1 || LOCK_COUNT > 255) begin : gen_bad_lock_count
    $fatal(1, "LOCK_COUNT must be 1..255");
  end
  if (UNLOCK_COUNT < 1 || UNLOCK_COUNT > 255) begin : gen_bad_unlock_count
    $fatal(1, "UNLOCK_COUNT must be 1..255");
  end

  align_state_e     state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [7:0]       match_q, match_d;
  logic [7:0]       mismatch_q, mismatch_d;
  logic [AttW-1:0]  attempts_q, attempts_d;
  logic [OffW-1:0]  offset_q, offset_d;
  logic [7:0]       relock_q, relock_d;
  logic             data_valid_q, data_valid_d;
  logic             locked_q;
  logic             align_fail_q, align_fail_d;

  logic [DATA_WIDTH-1:0] frame_aligned;
  logic                  frame_match;

  adc_word_shifter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_frame_shifter (
    .slow_clk (slow_clk),
    .reset_n  (reset_n),
    .offset   (offset_q),
    .cur_word (frame_word),
    .aligned  (frame_aligned)
  );

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    adc_word_shifter #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_shifter (
      .slow_clk (slow_clk),
      .reset_n  (reset_n),
      .offset   (offset_q),
      .cur_word (lane_data_in[k*DATA_WIDTH +: DATA_WIDTH]),
      .aligned  (lane_data_out[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign frame_match = (frame_aligned == FRAME_PATTERN[DATA_WIDTH-1:0]);

  always_ff @(posedge slow_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      wait_q       <= '0;
      match_q      <= '0;
      mismatch_q   <= '0;
      attempts_q   <= '0;
      offset_q     <= '0;
      relock_q     <= '0;
      data_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      align_fail_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      match_q      <= match_d;
      mismatch_q   <= mismatch_d;
      attempts_q   <= attempts_d;
      offset_q     <= offset_d;
      relock_q     <= relock_d;
      data_valid_q <= data_valid_d;
      locked_q     <= data_valid_d;
      align_fail_q <= align_fail_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    match_d    = '0;
    mismatch_d = '0;
    attempts_d = attempts_q;
    offset_d   = offset_q;
    relock_d   = relock_q;
    unique case (state_q)
      StIdle: begin
        attempts_d = '0;
        if (ena) state_d = StSettle;
      end
      StSettle: begin
        if (wait_q == WaitLast) state_d = StCheck;
        else                    wait_d  = wait_q + WaitW'(1);
      end
      StCheck: begin
        if (frame_match) begin
          match_d = match_q + 8'd1;
          if (match_q == LockLast) state_d = StLocked;
        end else begin
          state_d = StSlip;
        end
      end
      StSlip: begin
        // DATA_WIDTH is a power of two, so the natural wrap is mod DATA_WIDTH.
        offset_d   = offset_q + OffW'(1);
        attempts_d = attempts_q + AttW'(1);
        state_d    = (attempts_q == AttLast) ? StFail : StSettle;
      end
      StLocked: begin
        if (!frame_match) begin
          mismatch_d = mismatch_q + 8'd1;
          if (mismatch_q == UnlockLast) begin
            mismatch_d = '0;
            attempts_d = '0;
            relock_d   = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
            state_d    = StSettle;
          end
        end
      end
      StFail: ;
      default: state_d = StIdle;
    endcase
    if (!ena) begin
      state_d    = StIdle;
      wait_d     = '0;
      match_d    = '0;
      mismatch_d = '0;
      attempts_d = '0;
      offset_d   = offset_q;
      relock_d   = relock_q;
    end
  end

  // Valid only once LOCKED has been held for a cycle and is not being left.
  always_comb begin
    data_valid_d = (state_q == StLocked) && (state_d == StLocked);
    align_fail_d = (state_d == StFail);
  end

  assign data_valid    = data_valid_q;
  assign locked        = locked_q;
  assign align_fail    = align_fail_q;
  assign bitslip_count = offset_q;
  assign relock_count  = relock_q;

endmodule
